// File: rtl/ivl_uvm_ovl_step_pkg.sv
// Shared types and fire-bus indices for the step checker.
// Imported by the checker top and its step-arithmetic sub-module.
package ivl_uvm_ovl_step_pkg;

    typedef enum logic [1:0] {
        STEP_DEC = 2'd0,
        STEP_INC = 2'd1,
        STEP_ANY = 2'd2
    } step_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    localparam int FIRE_STEP  = 0;
    localparam int FIRE_XZ    = 1;
    localparam int FIRE_COVER = 2;

endpackage

// File: rtl/ivl_uvm_ovl_step_calc.sv
// Step arithmetic and legality test between the held reference and the new sample.
// Purely combinational; no latency, no flow control.
module ivl_uvm_ovl_step_calc
    import ivl_uvm_ovl_step_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int MODE       = 0,
    parameter int MIN_STEP   = 1,
    parameter int MAX_STEP   = 1,
    parameter int ALLOW_WRAP = 1
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] test_expr,
    output logic [WIDTH:0]   dn,
    output logic [WIDTH:0]   up,
    output logic             wrap_dn,
    output logic             wrap_up,
    output logic             legal
);

    localparam logic [WIDTH:0] MIN_V = (WIDTH+1)'(MIN_STEP);
    localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MAX_STEP);
    localparam logic [WIDTH:0] MASK  = {1'b0, {WIDTH{1'b1}}};

    logic dec_ok;
    logic inc_ok;

    // Differences are taken one bit wider, then folded back modulo 2**WIDTH.
    assign dn      = ({1'b0, prev} - {1'b0, test_expr}) & MASK;
    assign up      = ({1'b0, test_expr} - {1'b0, prev}) & MASK;
    assign wrap_dn = test_expr > prev;
    assign wrap_up = test_expr < prev;

    assign dec_ok = (dn >= MIN_V) && (dn <= MAX_V) && ((ALLOW_WRAP != 0) || !wrap_dn);
    assign inc_ok = (up >= MIN_V) && (up <= MAX_V) && ((ALLOW_WRAP != 0) || !wrap_up);

    always_comb begin
        legal = dec_ok | inc_ok;
        if (MODE == int'(STEP_DEC)) begin
            legal = dec_ok;
        end else if (MODE == int'(STEP_INC)) begin
            legal = inc_ok;
        end
    end

endmodule

// File: rtl/ivl_uvm_ovl_step_checker.sv
// Step-size checker: flags illegal changes of test_expr, X/Z samples and legal-change cover.
// Fire bits registered one cycle after the sample; no backpressure. IVL_OVL_STEP_MSG_EN adds $error reports.
module ivl_uvm_ovl_step_checker
    import ivl_uvm_ovl_step_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int MODE       = 0,
    parameter int MIN_STEP   = 1,
    parameter int MAX_STEP   = 1,
    parameter int ALLOW_WRAP = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     test_expr,
    output logic [2:0]           fire,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 armed
);

    if (MIN_STEP > MAX_STEP || MIN_STEP == 0 || MODE > 2) begin : g_bad_cfg
        $error("ivl_uvm_ovl_step_checker: illegal MODE/MIN_STEP/MAX_STEP combination");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [2:0]       fire_d;
    logic             known;
    logic [WIDTH:0]   dn, up;
    logic             wrap_dn, wrap_up, legal;

    assign known = !$isunknown(test_expr);
    assign armed = (state_q == ARMED);

    ivl_uvm_ovl_step_calc #(
        .WIDTH      (WIDTH),
        .MODE       (MODE),
        .MIN_STEP   (MIN_STEP),
        .MAX_STEP   (MAX_STEP),
        .ALLOW_WRAP (ALLOW_WRAP)
    ) u_calc (
        .prev      (prev_q),
        .test_expr (test_expr),
        .dn        (dn),
        .up        (up),
        .wrap_dn   (wrap_dn),
        .wrap_up   (wrap_up),
        .legal     (legal)
    );

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        fire_d  = 3'b000;
        if (enable && !known) begin
            fire_d[FIRE_XZ] = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (known) begin
                    prev_d  = test_expr;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!known) begin
                    state_d = IDLE;
                end else begin
                    // Reference tracks every known sample, even while checking is disabled.
                    prev_d = test_expr;
                    if (enable && (test_expr != prev_q)) begin
                        if (legal) begin
                            fire_d[FIRE_COVER] = 1'b1;
                        end else begin
                            fire_d[FIRE_STEP] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            fire      <= 3'b000;
            err_count <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            fire    <= fire_d;
            if (fire_d[FIRE_STEP] && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

`ifdef IVL_OVL_STEP_MSG_EN
    always @(posedge clock) begin
        if (reset && fire_d[FIRE_STEP]) begin
            $error("%0t step violation: prev=%0d test_expr=%0d dn=%0d up=%0d wrap_dn=%0b wrap_up=%0b",
                   $time, prev_q, test_expr, dn, up, wrap_dn, wrap_up);
        end
        if (reset && fire_d[FIRE_XZ]) begin
            $error("%0t X/Z on test_expr: prev=%0d test_expr=%b dn=%0d up=%0d",
                   $time, prev_q, test_expr, dn, up);
        end
    end
`else
    logic unused_calc;
    assign unused_calc = ^{dn, up, wrap_dn, wrap_up};
`endif

endmodule

// File: tb/tb_ivl_uvm_ovl_step_checker.sv
// Drives three checker configurations with directed and random stimulus and
// compares fire/err_count/armed against an arithmetic reference model every cycle.
module tb_ivl_uvm_ovl_step_checker;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] s2 = 2'd0;
    logic [3:0] s4 = 4'd0;

    logic [2:0] fire_a, fire_b, fire_c;
    logic [7:0] err_a, err_b;
    logic [1:0] err_c;
    logic       armed_a, armed_b, armed_c;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-instance configuration: a = defaults, b = wide bidirectional no-wrap, c = tiny counter.
    localparam int P_W    [3] = '{2, 4, 2};
    localparam int P_MODE [3] = '{0, 2, 0};
    localparam int P_MIN  [3] = '{1, 2, 1};
    localparam int P_MAX  [3] = '{1, 3, 1};
    localparam int P_WRAP [3] = '{1, 0, 1};
    localparam int P_ERRW [3] = '{8, 8, 2};

    int       prev_m [3];
    bit       arm_m  [3];
    int       err_m  [3];
    bit [2:0] fire_m [3];

    always #5 clock = ~clock;

    ivl_uvm_ovl_step_checker u_a (
        .clock(clock), .reset(reset), .enable(enable), .test_expr(s2),
        .fire(fire_a), .err_count(err_a), .armed(armed_a)
    );

    ivl_uvm_ovl_step_checker #(
        .WIDTH(4), .MODE(2), .MIN_STEP(2), .MAX_STEP(3), .ALLOW_WRAP(0)
    ) u_b (
        .clock(clock), .reset(reset), .enable(enable), .test_expr(s4),
        .fire(fire_b), .err_count(err_b), .armed(armed_b)
    );

    ivl_uvm_ovl_step_checker #(
        .ERR_CNT_W(2)
    ) u_c (
        .clock(clock), .reset(reset), .enable(enable), .test_expr(s2),
        .fire(fire_c), .err_count(err_c), .armed(armed_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Legality from first principles: modular distance in each direction, range and crossing.
    function automatic bit step_ok(input int i, input int p, input int v);
        int  m, dn, up;
        bit  dec, inc;
        m   = 1 << P_W[i];
        dn  = (p - v + m) % m;
        up  = (v - p + m) % m;
        dec = (dn >= P_MIN[i]) && (dn <= P_MAX[i]) && (P_WRAP[i] != 0 || v <= p);
        inc = (up >= P_MIN[i]) && (up <= P_MAX[i]) && (P_WRAP[i] != 0 || v >= p);
        case (P_MODE[i])
            0:       return dec;
            1:       return inc;
            default: return dec || inc;
        endcase
    endfunction

    task automatic model(input int i, input bit known, input int v, input bit en);
        fire_m[i] = 3'b000;
        if (en && !known) fire_m[i][1] = 1'b1;
        if (!arm_m[i]) begin
            if (known) begin
                prev_m[i] = v;
                arm_m[i]  = 1'b1;
            end
        end else if (!known) begin
            arm_m[i] = 1'b0;
        end else begin
            if (en && v != prev_m[i]) begin
                if (step_ok(i, prev_m[i], v)) begin
                    fire_m[i][2] = 1'b1;
                end else begin
                    fire_m[i][0] = 1'b1;
                    if (err_m[i] < (1 << P_ERRW[i]) - 1) err_m[i]++;
                end
            end
            prev_m[i] = v;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            prev_m[i] = 0;
            arm_m[i]  = 1'b0;
            err_m[i]  = 0;
            fire_m[i] = 3'b000;
        end
    endtask

    task automatic check_all();
        check("a_fire",  32'(fire_a),  32'(fire_m[0]));
        check("a_err",   32'(err_a),   32'(err_m[0]));
        check("a_armed", 32'(armed_a), 32'(arm_m[0]));
        check("b_fire",  32'(fire_b),  32'(fire_m[1]));
        check("b_err",   32'(err_b),   32'(err_m[1]));
        check("b_armed", 32'(armed_b), 32'(arm_m[1]));
        check("c_fire",  32'(fire_c),  32'(fire_m[2]));
        check("c_err",   32'(err_c),   32'(err_m[2]));
        check("c_armed", 32'(armed_c), 32'(arm_m[2]));
    endtask

    // Inputs change 1 time unit after a posedge; outputs are compared 1 unit after the next one.
    task automatic tick(input logic [1:0] v2, input logic [3:0] v4, input bit en);
        s2     = v2;
        s4     = v4;
        enable = en;
        @(posedge clock);
        model(0, !$isunknown(v2), int'(v2), en);
        model(1, !$isunknown(v4), int'(v4), en);
        model(2, !$isunknown(v2), int'(v2), en);
        #1 check_all();
    endtask

    // Asserts reset between edges and checks that outputs clear before any clock edge.
    task automatic pulse_reset();
        #2 reset = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clock);
        #1 check_all();
        #2 reset = 1'b1;
    endtask

    initial begin
        int cur4;
        logic [1:0] v2;
        logic [3:0] v4;

        model_reset();
        #1 check_all();
        @(posedge clock);
        #1 reset = 1'b1;

        // Down-count with wrap on the default instance; b walks 8,5,6,10,1,15.
        tick(2'd3, 4'd8, 1'b1);
        tick(2'd2, 4'd5, 1'b1);
        tick(2'd1, 4'd6, 1'b1);
        tick(2'd0, 4'd10, 1'b1);
        tick(2'd3, 4'd1, 1'b1);
        tick(2'd1, 4'd15, 1'b1);
        // Increment is a violation in decrement-only mode, then a long hold.
        tick(2'd2, 4'd15, 1'b1);
        tick(2'd1, 4'd15, 1'b1);
        for (int k = 0; k < 50; k++) tick(2'd1, 4'd15, 1'b1);

        // Unknown samples from reset release: X/Z fire every cycle, never armed.
        pulse_reset();
        for (int k = 0; k < 50; k++) tick('x, 'x, 1'b1);
        tick(2'd1, 4'd3, 1'b1);
        for (int k = 0; k < 5; k++) tick(2'd1, 4'd3, 1'b1);

        // Disabled change is tracked silently; re-enabling on the held value is quiet.
        tick(2'd2, 4'd4, 1'b0);
        tick(2'd3, 4'd6, 1'b0);
        tick(2'd3, 4'd6, 1'b1);
        tick(2'd3, 4'd6, 1'b1);

        // Five violations saturate the 2-bit counter, then reset mid-run.
        pulse_reset();
        tick(2'd0, 4'd0, 1'b1);
        tick(2'd1, 4'd1, 1'b1);
        tick(2'd2, 4'd2, 1'b1);
        tick(2'd3, 4'd3, 1'b1);
        tick(2'd0, 4'd0, 1'b1);
        tick(2'd1, 4'd1, 1'b1);
        tick(2'd1, 4'd1, 1'b1);
        pulse_reset();

        cur4 = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) v2 = 'x;
            else v2 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) begin
                v4 = 'x;
            end else begin
                cur4 = (cur4 + int'($urandom_range(0, 8)) + 12) % 16;
                v4   = 4'(cur4);
            end
            tick(v2, v4, $urandom_range(0, 7) != 0);
            if ($urandom_range(0, 299) == 0) pulse_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
